// File: rtl/mem_pkg.sv
// Shared defaults and helpers for the multi-channel scratch memory and its arbiter.
// Parameterised modules take their defaults from here and derive their own widths locally.
package mem_pkg;

    localparam int DEF_DATA_LENGTH = 32;
    localparam int DEF_ADDR_SIZE   = 4;
    localparam int DEF_NUM_CH      = 2;

    localparam int BE_W  = DEF_DATA_LENGTH / 8;
    localparam int DEPTH = 2 ** DEF_ADDR_SIZE;

    // A single-channel build still needs a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CH_IDX_W = idx_width(DEF_NUM_CH);
    typedef logic [CH_IDX_W-1:0] ch_idx_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, registered rotating priority pointer.
// Also intended for reuse by the bus fabric.
module rr_arbiter
    import mem_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    output logic [NUM_CH-1:0] gnt
);

    localparam int PTR_W = idx_width(NUM_CH);

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_ptr_nxt;
    logic [PTR_W-1:0] w_idx;
    logic [PTR_W:0]   w_sum;
    logic             w_hit;

    // Scan from r_ptr upward, wrapping at NUM_CH; the first requester wins.
    always_comb begin
        gnt       = '0;
        w_hit     = 1'b0;
        w_ptr_nxt = r_ptr;
        w_sum     = '0;
        w_idx     = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_sum = {1'b0, r_ptr} + (PTR_W+1)'(k);
            if (w_sum >= (PTR_W+1)'(NUM_CH)) begin
                w_sum = w_sum - (PTR_W+1)'(NUM_CH);
            end
            w_idx = w_sum[PTR_W-1:0];
            if (!w_hit && req[w_idx]) begin
                gnt[w_idx] = 1'b1;
                w_hit      = 1'b1;
                w_ptr_nxt  = (w_idx == PTR_W'(NUM_CH - 1)) ? '0 : w_idx + PTR_W'(1);
            end
        end
        if (rst) begin
            gnt = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_hit) begin
            r_ptr <= w_ptr_nxt;
        end
    end

endmodule

// File: rtl/mc_memory_rr.sv
// Multi-channel single-port scratch memory: round-robin access, byte-enabled writes,
// registered reads returned on a shared rdata bus with a per-channel rvalid strobe.
module mc_memory_rr
    import mem_pkg::*;
#(
    parameter int DATA_LENGTH = DEF_DATA_LENGTH,
    parameter int ADDR_SIZE   = DEF_ADDR_SIZE,
    parameter int NUM_CH      = DEF_NUM_CH
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_CH-1:0]                   valid,
    input  logic [NUM_CH-1:0]                   wr_rd,
    input  logic [NUM_CH*ADDR_SIZE-1:0]         addr,
    input  logic [NUM_CH*DATA_LENGTH-1:0]       wdata,
    input  logic [NUM_CH*(DATA_LENGTH/8)-1:0]   be,
    output logic [NUM_CH-1:0]                   ready,
    output logic [NUM_CH-1:0]                   rvalid,
    output logic [DATA_LENGTH-1:0]              rdata
);

    localparam int LBE_W   = DATA_LENGTH / 8;
    localparam int LDEPTH  = 2 ** ADDR_SIZE;

    if (DATA_LENGTH % 8 != 0) begin : g_bad_width
        $error("mc_memory_rr: DATA_LENGTH must be a multiple of 8");
    end
    if (NUM_CH < 2 || NUM_CH > 8) begin : g_bad_ch
        $error("mc_memory_rr: NUM_CH must be in 2..8");
    end

    logic [NUM_CH-1:0]      w_gnt;
    logic                   w_any;
    logic                   w_wr;
    logic [ADDR_SIZE-1:0]   w_addr;
    logic [DATA_LENGTH-1:0] w_wdata;
    logic [LBE_W-1:0]       w_be;

    logic [DATA_LENGTH-1:0] r_mem [LDEPTH];
    logic [DATA_LENGTH-1:0] r_rdata;
    logic [NUM_CH-1:0]      r_rvalid;

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .clk (clk),
        .rst (rst),
        .req (valid),
        .gnt (w_gnt)
    );

    assign ready  = w_gnt;
    assign rvalid = r_rvalid;
    assign rdata  = r_rdata;

    // Grant is one-hot, so an OR-style mux picks the winning channel's request fields.
    always_comb begin
        w_any   = |w_gnt;
        w_wr    = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        w_be    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_gnt[i]) begin
                w_wr    = wr_rd[i];
                w_addr  = addr[i*ADDR_SIZE +: ADDR_SIZE];
                w_wdata = wdata[i*DATA_LENGTH +: DATA_LENGTH];
                w_be    = be[i*LBE_W +: LBE_W];
            end
        end
    end

    // Reset clears the whole array and drops any read that would otherwise respond.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < LDEPTH; j++) begin
                r_mem[j] <= '0;
            end
            r_rdata  <= '0;
            r_rvalid <= '0;
        end else begin
            r_rvalid <= '0;
            if (w_any) begin
                if (w_wr) begin
                    for (int b = 0; b < LBE_W; b++) begin
                        if (w_be[b]) begin
                            r_mem[w_addr][8*b +: 8] <= w_wdata[8*b +: 8];
                        end
                    end
                end else begin
                    r_rdata  <= r_mem[w_addr];
                    r_rvalid <= w_gnt;
                end
            end
        end
    end

endmodule

// File: tb/tb_mc_memory_rr.sv
// Directed self-checking bench for mc_memory_rr (two channels, 32-bit words, 16-deep).
`timescale 1ns/1ps
module tb_mc_memory_rr;

    logic        clk;
    logic        rst;
    logic [1:0]  valid;
    logic [1:0]  wr_rd;
    logic [7:0]  addr;
    logic [63:0] wdata;
    logic [7:0]  be;
    logic [1:0]  ready;
    logic [1:0]  rvalid;
    logic [31:0] rdata;

    int checks = 0;
    int errors = 0;
    int cnt0   = 0;
    int cnt1   = 0;

    mc_memory_rr #(
        .DATA_LENGTH (32),
        .ADDR_SIZE   (4),
        .NUM_CH      (2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .valid  (valid),
        .wr_rd  (wr_rd),
        .addr   (addr),
        .wdata  (wdata),
        .be     (be),
        .ready  (ready),
        .rvalid (rvalid),
        .rdata  (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid = '0;
        wr_rd = '0;
        be    = '0;
    endtask

    task automatic drive(input int ch, input logic wr, input logic [3:0] a,
                         input logic [31:0] d, input logic [3:0] b);
        valid[ch]         = 1'b1;
        wr_rd[ch]         = wr;
        addr[ch*4 +: 4]   = a;
        wdata[ch*32 +: 32] = d;
        be[ch*4 +: 4]     = b;
    endtask

    initial begin
        rst   = 1'b1;
        valid = 2'b11;
        wr_rd = '0;
        addr  = '0;
        wdata = '0;
        be    = '0;
        #1;
        chk("ready_in_reset", ready, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_rvalid", rvalid, 2'b00);

        // Reset then read
        drive(0, 1'b0, 4'd5, 32'h0, 4'h0);
        #1 chk("t1_ready", ready, 2'b01);
        cyc();
        idle();
        chk("t1_rvalid", rvalid, 2'b01);
        chk("t1_rdata", rdata, 32'h0);

        // Byte-enable write then read back
        drive(1, 1'b1, 4'd3, 32'hAABBCCDD, 4'b1111);
        #1 chk("t2_ready_w1", ready, 2'b10);
        cyc();
        chk("t2_rvalid_w1", rvalid, 2'b00);
        drive(1, 1'b1, 4'd3, 32'h11223344, 4'b0101);
        #1 chk("t2_ready_w2", ready, 2'b10);
        cyc();
        drive(1, 1'b0, 4'd3, 32'h0, 4'b0000);
        cyc();
        idle();
        chk("t2_rvalid_rd", rvalid, 2'b10);
        chk("t2_rdata", rdata, 32'hAA22CC44);

        // Fairness: preload addr1/addr2, then both channels read continuously
        drive(0, 1'b1, 4'd1, 32'h01010101, 4'hF);
        cyc();
        idle();
        drive(1, 1'b1, 4'd2, 32'h02020202, 4'hF);
        cyc();
        idle();
        drive(0, 1'b0, 4'd1, 32'h0, 4'h0);
        drive(1, 1'b0, 4'd2, 32'h0, 4'h0);
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("t3_ready_%0d", k), ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            if (ready == 2'b01) cnt0++;
            if (ready == 2'b10) cnt1++;
            cyc();
            chk($sformatf("t3_rvalid_%0d", k), rvalid, (k % 2 == 0) ? 2'b01 : 2'b10);
            chk($sformatf("t3_rdata_%0d", k), rdata,
                (k % 2 == 0) ? 32'h01010101 : 32'h02020202);
        end
        idle();
        chk("t3_cnt0", cnt0, 3);
        chk("t3_cnt1", cnt1, 3);

        // Read-after-write across channels
        drive(0, 1'b1, 4'd7, 32'hDEADBEEF, 4'hF);
        drive(1, 1'b0, 4'd7, 32'h0, 4'h0);
        #1 chk("t4_ready_w", ready, 2'b01);
        cyc();
        chk("t4_rvalid_w", rvalid, 2'b00);
        valid[0] = 1'b0;
        #1 chk("t4_ready_r", ready, 2'b10);
        cyc();
        idle();
        chk("t4_rvalid", rvalid, 2'b10);
        chk("t4_rdata", rdata, 32'hDEADBEEF);

        // Idle hold
        drive(0, 1'b1, 4'd9, 32'h12345678, 4'hF);
        cyc();
        drive(0, 1'b0, 4'd9, 32'h0, 4'h0);
        cyc();
        idle();
        chk("t6_rdata0", rdata, 32'h12345678);
        for (int k = 0; k < 4; k++) begin
            #1 chk($sformatf("t6_ready_%0d", k), ready, 2'b00);
            cyc();
            chk($sformatf("t6_rvalid_%0d", k), rvalid, 2'b00);
            chk($sformatf("t6_rdata_%0d", k), rdata, 32'h12345678);
        end
        valid = 2'b11;
        #1 chk("t6_ptr_held", ready, 2'b10);
        idle();

        // Reset mid-operation
        drive(0, 1'b0, 4'd7, 32'h0, 4'h0);
        #1 chk("t5_ready_pre", ready, 2'b01);
        #2 rst = 1'b1;
        #1;
        chk("t5_ready_rst", ready, 2'b00);
        chk("t5_rvalid_rst", rvalid, 2'b00);
        chk("t5_rdata_rst", rdata, 32'h0);
        cyc();
        rst = 1'b0;
        idle();
        cyc();
        chk("t5_rvalid_after", rvalid, 2'b00);
        chk("t5_rdata_after", rdata, 32'h0);
        drive(1, 1'b1, 4'd0, 32'hCAFEF00D, 4'hF);
        cyc();
        idle();
        drive(1, 1'b0, 4'd0, 32'h0, 4'h0);
        cyc();
        idle();
        chk("t5_rdata_marker", rdata, 32'hCAFEF00D);
        drive(0, 1'b0, 4'd7, 32'h0, 4'h0);
        cyc();
        idle();
        chk("t5_rvalid_a7", rvalid, 2'b01);
        chk("t5_rdata_a7", rdata, 32'h0);
        drive(0, 1'b0, 4'd3, 32'h0, 4'h0);
        cyc();
        idle();
        chk("t5_rdata_a3", rdata, 32'h0);
        drive(0, 1'b0, 4'd9, 32'h0, 4'h0);
        cyc();
        idle();
        chk("t5_rdata_a9", rdata, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mc_memory_rr.md
Name: mc_memory_rr

Overview:
- Multi-channel successor to the team's single-port memory: NUM_CH requestors share one single-port array of 2**ADDR_SIZE words.
- Round-robin arbitration; one access per cycle.
- Byte-enabled writes; registered reads returned with a per-channel response strobe.
- Sits between several bus masters (DMA, CPU, debug) and on-chip scratch storage.

Parameters:
- DATA_LENGTH, 32, word width in bits; must be a multiple of 8.
- ADDR_SIZE, 4, address width; depth = 2**ADDR_SIZE words.
- NUM_CH, 2, number of requestor channels; 2..8.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- valid  input  NUM_CH  per-channel request valid.
- wr_rd  input  NUM_CH  per-channel direction: 1 = write, 0 = read.
- addr  input  NUM_CH*ADDR_SIZE  packed per-channel address; channel i in slice [i*ADDR_SIZE +: ADDR_SIZE].
- wdata  input  NUM_CH*DATA_LENGTH  packed per-channel write data.
- be  input  NUM_CH*(DATA_LENGTH/8)  packed per-channel byte enables (writes only).
- ready  output  NUM_CH  per-channel grant, combinational; one-hot or zero.
- rvalid  output  NUM_CH  registered, one-cycle read-response strobe for the channel that issued the read.
- rdata  output  DATA_LENGTH  registered read data, shared by all channels; qualified by rvalid.

Behaviour:
- Reset (rst=1, async):
  - Every memory word cleared to 0.
  - rdata=0, rvalid=0, round-robin pointer rr_ptr=0.
  - ready forced to 0 while rst is high.
  - Any read in flight is dropped; no rvalid is produced for it after reset releases.
- Handshake:
  - A transfer on channel i occurs in the cycle where valid[i] & ready[i].
  - The requestor holds valid, wr_rd, addr, wdata and be stable until ready.
  - Deasserting valid before grant is legal and withdraws the request.
  - ready[i] never asserts without valid[i].
- Arbitration:
  - Scan channels starting at rr_ptr, ascending modulo NUM_CH; the first one with valid set is granted.
  - At most one grant per cycle.
  - On a grant to channel g, rr_ptr <= (g+1) mod NUM_CH at posedge.
  - With no valid, rr_ptr holds.
  - A single continuously requesting channel is granted every cycle.
  - With all NUM_CH channels requesting, each is granted exactly once per NUM_CH cycles.
- Write (granted, wr_rd=1):
  - At posedge, for each byte b with be[b]=1, mem[addr][8b+7:8b] <= wdata byte b; other bytes are unchanged.
  - be=0 is a legal no-op that still consumes the slot.
  - rvalid stays 0 for writes.
- Read (granted, wr_rd=0):
  - At posedge, rdata <= mem[addr] and rvalid <= one-hot of the granted channel.
  - Latency: exactly 1 cycle from the transfer edge.
- rdata hold rule: rdata holds its last value when no read completes. rvalid returns to 0 the cycle after, unless back-to-back reads keep it asserted.
- Read-after-write: a write at edge N followed by a read of the same address granted at edge N+1 returns the written data. No forwarding path is needed, since there is only one access per cycle.
- Address range: addresses are always in range (full 2**ADDR_SIZE decode); there is no error path.
- Width rule: DATA_LENGTH%8 != 0 is illegal; flag it with an elaboration-time check.

Decomposition:
- Shared package mem_pkg:
  - Localparams: BE_W = DATA_LENGTH/8 and DEPTH = 2**ADDR_SIZE.
  - Typedef for the channel-index type, $clog2(NUM_CH) wide, minimum 1.
- One sub-module: rr_arbiter.
  - Parameter NUM_CH.
  - Ports clk, rst, req[NUM_CH], gnt[NUM_CH].
  - Holds rr_ptr; gnt is combinational and the pointer is registered.
  - Reused later by the team's bus fabric.

Test Plan:
1. Reset then read: assert rst for 2 cycles, then channel 0 reads addr 5 → rvalid=01 one cycle after the grant, rdata=0x00000000.
2. Byte-enable write: channel 1 writes addr 3, wdata=0xAABBCCDD, be=1111. Then channel 1 writes addr 3, wdata=0x11223344, be=0101. Then it reads addr 3 → rdata=0xAA22CC44.
3. Fairness: NUM_CH=2, both channels hold valid for 6 cycles (reads of addr 1 and addr 2) → grants alternate ch0,ch1,ch0,…, 3 each; rvalid alternates 01,10 one cycle behind.
4. Read-after-write: channel 0 writes addr 7=0xDEADBEEF with be=1111. Channel 1's read of addr 7 is granted the next cycle → rdata=0xDEADBEEF, rvalid=10.
5. Reset mid-operation: channel 0 read granted, then rst pulsed before the next posedge → rvalid stays 0, rdata=0, and all previously written words read back 0 afterwards.
6. Idle hold: after a read returns 0x12345678, keep valid=0 for 4 cycles → rvalid=0, rdata holds 0x12345678, ready=0, rr_ptr unchanged.
